sar_search: RTL and testbench
=============================

// Module: sar_search
// PURPOSE
//  Successive-approximation controller: the driving end of an unsigned >= comparator.
//  - Drives trial words into an external UGE<N> comparator (ge = target >= trial).
//  - Recovers the unknown unsigned target by binary search, one bit per probe, MSB first.
//  - Sits beside compare-based datapaths (threshold recovery, SAR-ADC style loops on iCE40).
// PARAMETERS
//  N       4   width of trial/result words; >= 1
// PORTS
//  CLK     in   1  rising-edge clock
//  RESETN  in   1  asynchronous, active-low reset
//  START   in   1  request a search; sampled in IDLE only
//  GE      in   1  comparator result for the current TRIAL (1 = target >= TRIAL)
//  TRIAL   out  N  word presented to the comparator
//  RESULT  out  N  recovered target; valid while DONE=1 and held until the next START
//  BUSY    out  1  high while a search is in progress
//  DONE    out  1  one-cycle pulse when RESULT becomes valid
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (RESETN), clock is CLK.
//  - Reset values: state=IDLE, TRIAL=0, RESULT=0, BUSY=0, DONE=0, bit index k=N-1.
//  - States: IDLE -> PROBE -> FINISH -> IDLE.
//  - IDLE
//    - TRIAL=0.
//    - START=1 at an edge: clear RESULT, set k=N-1, go to PROBE.
//  - PROBE
//    - BUSY=1.
//    - TRIAL = RESULT | (1<<k), decoded combinationally from registers.
//    - At each edge GE is sampled: if GE, RESULT[k]<=1, else RESULT[k] stays 0.
//    - If k==0, go to FINISH; otherwise k<=k-1.
//  - FINISH
//    - DONE=1 and BUSY=0 for exactly one cycle; RESULT final; then IDLE.
//  - Latency: START edge + N probe cycles + 1 DONE cycle. For N=4, DONE is high in cycle 5 after the START edge.
//  - START while BUSY or DONE: ignored; no restart, no queueing.
//  - START held high continuously: a new search begins from the IDLE cycle after DONE.
//  - GE is used only in PROBE; it is don't-care elsewhere.
//  - RESETN low mid-search: immediate return to reset values; no DONE pulse.
//  - Arithmetic: RESULT and TRIAL are both N bits and never overflow.
//    - Target 2^N-1 yields all GE=1 and RESULT = all ones.
//    - Target 0 yields TRIAL sequence 2^(N-1), 2^(N-2), ..., 1 and RESULT=0.
// CONFIGURATION
//  SAR_GE_REG_EN
//  - Defined: GE passes through an input register. Each bit takes 2 cycles:
//    - SETTLE: TRIAL driven, GE ignored.
//    - SAMPLE: registered GE used.
//    - Search latency becomes 2N probe cycles + 1 DONE cycle.
//    - TRIAL is stable across both cycles of each bit.
//  - Undefined: combinational GE sampled in the same cycle; 1 cycle per bit.
// STRUCTURE
//  - Package sar_pkg:
//    - state enum {IDLE, PROBE, FINISH}; with SAR_GE_REG_EN add SETTLE.
//    - localparam for the bit-index width $clog2(N) (minimum 1).
//  - Sub-module sar_trial_dec: combinational one-hot(k) OR RESULT -> TRIAL.
//  - The FSM and registers live in sar_search.
// TESTING
//  - Bench closes the loop with a behavioural UGE<N> model: GE = (target >= TRIAL).
//  - N=4, target=9, pulse START:
//    - TRIAL sequence 8, 12, 10, 9.
//    - GE sequence 1, 0, 0, 1.
//    - DONE pulses once, RESULT=9.
//  - target=0: TRIAL 8, 4, 2, 1; RESULT=0. target=15: TRIAL 8, 12, 14, 15; RESULT=15.
//  - Sweep target 0..15 back-to-back with START held high: RESULT==target each time, one DONE per search.
//  - START pulsed during PROBE (cycle 2): ignored; RESULT and timing match the single-start run.
//  - RESETN driven low in probe cycle 3, asynchronously:
//    - All outputs return to 0 at once; no DONE.
//    - A later START completes normally.
//  - With SAR_GE_REG_EN, target=9:
//    - Each TRIAL value is held 2 cycles.
//    - DONE arrives in cycle 9 after the START edge; RESULT=9.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the successive-approximation search.
// Optional build macro: SAR_GE_REG_EN adds the SETTLE state used when the
// comparator result is registered before use.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    FINISH = 2'd2
`ifdef SAR_GE_REG_EN
    ,
    SETTLE = 2'd3
`endif
  } sar_state_t;

  // Bit-index width for an n-bit search; never narrower than one bit.
  function automatic int sar_kw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SAR_N_DEFAULT  = 4;
  localparam int SAR_KW_DEFAULT = sar_kw(SAR_N_DEFAULT);

endpackage

// File: rtl/sar_trial_dec.sv
// Trial-word decoder: the bits already decided (result) with the bit under
// test (k) forced to one. Outputs zero when no probe is active.
module sar_trial_dec #(
  parameter int N  = 4,
  parameter int KW = 2
) (
  input  logic          en,
  input  logic [KW-1:0] k,
  input  logic [N-1:0]  result,
  output logic [N-1:0]  trial
);

  logic [N-1:0] one_hot;

  // One-hot of the probe index merged with the decided bits.
  always_comb begin
    one_hot = '0;
    for (int i = 0; i < N; i++) begin
      one_hot[i] = (k == KW'(i));
    end
    trial = en ? (result | one_hot) : '0;
  end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation controller driving an external unsigned >=
// comparator (ge = target >= trial). Recovers the target MSB first.
// Optional build macro: SAR_GE_REG_EN registers ge; each bit then spends one
// SETTLE cycle (trial driven, ge ignored) and one PROBE cycle (registered ge
// used), with trial held across both.
//
// Handshake: start is sampled only in IDLE; a search then runs to completion
// with busy high, and done pulses for exactly one cycle when result becomes
// valid. result then holds until the next accepted start. start seen while
// busy or done is dropped, never queued.
module sar_search
  import sar_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         ge,
  output logic [N-1:0] trial,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done,
  output sar_state_t   state_dbg
);

  localparam int KW = sar_kw(N);

  sar_state_t    state, state_nxt;
  logic [KW-1:0] k;
  logic          ge_use;

`ifdef SAR_GE_REG_EN
  logic ge_q;

  // Input register for the comparator result; captured every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ge_q <= 1'b0;
    else         ge_q <= ge;
  end

  assign ge_use = ge_q;
`else
  assign ge_use = ge;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode: one probe per bit, then a single FINISH cycle.
  always_comb begin
    state_nxt = state;
    case (state)
`ifdef SAR_GE_REG_EN
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: state_nxt = PROBE;
      PROBE:  state_nxt = (k == '0) ? FINISH : SETTLE;
`else
      IDLE:   if (start) state_nxt = PROBE;
      PROBE:  state_nxt = (k == '0) ? FINISH : PROBE;
`endif
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: status flags come straight from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
`ifdef SAR_GE_REG_EN
      SETTLE: busy = 1'b1;
`endif
      PROBE:  busy = 1'b1;
      FINISH: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Search registers: clear on accepted start, resolve one bit per PROBE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result <= '0;
      k      <= KW'(N - 1);
    end else if (state == IDLE && start) begin
      result <= '0;
      k      <= KW'(N - 1);
    end else if (state == PROBE) begin
      if (ge_use) result[k] <= 1'b1;
      if (k != '0) k <= k - KW'(1);
    end
  end

  sar_trial_dec #(
    .N  (N),
    .KW (KW)
  ) u_trial_dec (
    .en     (busy),
    .k      (k),
    .result (result),
    .trial  (trial)
  );

  assign state_dbg = state;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: closes the loop with a behavioural comparator and
// checks trial sequences, latency, result and the done pulse.
module tb_sar_search;
  import sar_pkg::*;

  localparam int N = 4;
`ifdef SAR_GE_REG_EN
  localparam int CPB = 2;
`else
  localparam int CPB = 1;
`endif

  typedef logic [N-1:0] trial_arr_t [N];
  typedef struct {
    logic [N-1:0] target;
    trial_arr_t   trials;
    logic [N-1:0] result;
  } vec_t;

  logic         clk;
  logic         resetn;
  logic         start;
  logic         ge;
  logic [N-1:0] trial;
  logic [N-1:0] result;
  logic         busy;
  logic         done;
  sar_state_t   state_dbg;
  logic [N-1:0] tgt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];
  vec_t vecs [4];

  sar_search #(.N(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .ge        (ge),
    .trial     (trial),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural unsigned >= comparator
  always_comb ge = (tgt >= trial);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Probe b of a search: bits above the probe copied from the target,
  // probe bit set, bits below clear.
  function automatic logic [N-1:0] model_trial(input logic [N-1:0] t, input int b);
    int full, low, tr;
    full = (1 << N) - 1;
    low  = (1 << (N - b)) - 1;
    tr   = (int'(t) & (full ^ low)) | (1 << (N - 1 - b));
    return tr[N-1:0];
  endfunction

  // Start one search, follow it cycle by cycle. poke>0 raises start in that
  // probe cycle, which must be ignored.
  task automatic do_search(input logic [N-1:0] t, input trial_arr_t exp_tr,
                           input int poke, input string tag);
    int cyc;
    logic [N-1:0] exp_r;
    @(negedge clk);
    tgt   = t;
    start = 1'b1;
    exp_q.push_back(t);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    for (int b = 0; b < N; b++) begin
      for (int c = 0; c < CPB; c++) begin
        start = (cyc == poke);
        check({tag, "_trial"}, int'(trial), int'(exp_tr[b]));
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_nodone"}, int'(done), 0);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    exp_r = exp_q.pop_front();
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy_fin"}, int'(busy), 0);
    check({tag, "_result"}, int'(result), int'(exp_r));
    @(negedge clk);
    check({tag, "_done_once"}, int'(done), 0);
    check({tag, "_held"}, int'(result), int'(exp_r));
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
  endtask

  initial begin
    trial_arr_t tr;
    int cyc;
    logic [N-1:0] rt;

    vecs[0] = '{target: 4'd9,  trials: '{4'd8, 4'd12, 4'd10, 4'd9},  result: 4'd9};
    vecs[1] = '{target: 4'd0,  trials: '{4'd8, 4'd4,  4'd2,  4'd1},  result: 4'd0};
    vecs[2] = '{target: 4'd15, trials: '{4'd8, 4'd12, 4'd14, 4'd15}, result: 4'd15};
    vecs[3] = '{target: 4'd6,  trials: '{4'd8, 4'd4,  4'd6,  4'd7},  result: 4'd6};

    resetn = 1'b0;
    start  = 1'b0;
    tgt    = '0;
    #12;
    check("rst_trial", int'(trial), 0);
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    @(negedge clk);
    resetn = 1'b1;

    // table vectors
    for (int i = 0; i < 4; i++) begin
      do_search(vecs[i].target, vecs[i].trials, 0, "vec");
      check("vec_table_result", int'(result), int'(vecs[i].result));
    end

    // start pulsed mid-search must not disturb timing or result
    do_search(4'd9, vecs[0].trials, 2, "poke");

    // asynchronous reset mid-search
    @(negedge clk);
    tgt   = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_trial", int'(trial), 0);
    check("arst_result", int'(result), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) cyc++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 2 * N * CPB; i++) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("arst_no_done", cyc, 0);
    do_search(4'd9, vecs[0].trials, 0, "after_rst");

    // back-to-back sweep with start held high
    @(negedge clk);
    tgt   = 4'd0;
    start = 1'b1;
    for (int t = 0; t < (1 << N); t++) begin
      tgt = t[N-1:0];
      wait_done(4 * N * CPB, cyc);
      check("sweep_lat", cyc, (t == 0) ? N * CPB + 1 : N * CPB + 2);
      check("sweep_result", int'(result), t);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sweep_idle", int'(busy), 0);

    // random targets against the model
    for (int i = 0; i < 20; i++) begin
      rt = N'($urandom_range((1 << N) - 1, 0));
      for (int b = 0; b < N; b++) tr[b] = model_trial(rt, b);
      do_search(rt, tr, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
